// File: rtl/cpu_dbg_pkg.sv
// -----------------------------------------------------------------------------
// cpu_dbg_pkg
// Shared encodings for the CPU run controller: sequencer state, PDU command
// codes, halt-reason codes and the default counter width. Also carries the
// halt-reason priority helper so every user resolves simultaneous halt
// conditions the same way.
// -----------------------------------------------------------------------------
package cpu_dbg_pkg;

  localparam int CNT_W_DEFAULT = 32;
  localparam int PC_W_DEFAULT  = 32;

  // Sequencer states. cpu_en is high exactly in ST_STEP and ST_RUN.
  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_STEP = 2'b01,
    ST_RUN  = 2'b10
  } run_state_t;

  // PDU command codes.
  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_STEP = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_CLR  = 2'b11;

  // Halt reasons reported to the PDU.
  localparam logic [2:0] HR_STOP       = 3'b000;
  localparam logic [2:0] HR_STEP       = 3'b001;
  localparam logic [2:0] HR_BREAKPOINT = 3'b010;
  localparam logic [2:0] HR_SELF_LOOP  = 3'b011;
  localparam logic [2:0] HR_LIMIT      = 3'b100;

  // Resolve the reason when several RUN halt conditions fire together:
  // breakpoint > self-loop > budget limit > STOP command.
  function automatic logic [2:0] run_halt_reason(
    input logic bp_hit,
    input logic self_loop,
    input logic limit_hit
  );
    logic [2:0] reason;
    if (bp_hit)         reason = HR_BREAKPOINT;
    else if (self_loop) reason = HR_SELF_LOOP;
    else if (limit_hit) reason = HR_LIMIT;
    else                reason = HR_STOP;
    return reason;
  endfunction

endpackage

// File: rtl/instr_counter.sv
// -----------------------------------------------------------------------------
// instr_counter
// CNT_W-bit up counter with synchronous clear, increment enable and a
// limit register. at_limit flags the last allowed increment: it is high when
// a non-zero limit is loaded and count == limit - 1, so exactly `limit`
// increments happen before the owner stops incrementing. A limit of zero
// never matches (unlimited).
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   clr        count <= 0 next cycle; wins over inc
//   inc        count <= count + 1 (wraps modulo 2^CNT_W)
//   load       limit <= load_val
//   load_val   limit value to load
//   count      current count
//   at_limit   count == limit - 1 with limit != 0
// -----------------------------------------------------------------------------
module instr_counter
  import cpu_dbg_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      limit <= '0;
    end else if (load) begin
      limit <= load_val;
    end
  end

  assign at_limit = (limit != '0) && (count == (limit - ONE));

endmodule

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Execution sequencer for the single-cycle RV32 CPU. Owns cpu_en, the global
// commit enable (PC register, RF write enable and mem_we are all qualified by
// it at integration). Accepts STOP/STEP/RUN/CLR_CNT from the PDU, halts on
// breakpoint, self-loop or instruction budget, and reports halt status plus a
// retired-instruction count.
//
// Command handshake: a command is taken at a rising edge where cmd_valid and
// cmd_ready are both high; cmd is sampled only at that edge. cmd_ready is low
// only during the single STEP cycle. A taken command that makes no sense in
// the current state (STEP or RUN while running) is dropped and answered by a
// one-cycle cmd_err pulse in the following cycle.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   cmd_valid     PDU command strobe
//   cmd           00 STOP, 01 STEP, 10 RUN, 11 CLR_CNT
//   cmd_ready     command accepted when high together with cmd_valid
//   cmd_err       one-cycle pulse for a non-applicable command
//   bp_en         breakpoint enable
//   bp_addr       breakpoint PC (compared against next_pc)
//   run_limit     instructions per RUN, 0 = unlimited, sampled at RUN accept
//   current_pc    CPU PC
//   next_pc       CPU next PC
//   cpu_en        registered commit enable
//   halted        high in HALT
//   halt_reason   000 STOP/reset, 001 STEP, 010 BP, 011 SELF_LOOP, 100 LIMIT
//   instr_cnt     retired instructions (cycles with cpu_en=1), wraps
//   dbg_state     sequencer state (run_state_t encoding)
// -----------------------------------------------------------------------------
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  output logic             cmd_err,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [CNT_W-1:0] run_limit,
  input  logic [PC_W-1:0]  current_pc,
  input  logic [PC_W-1:0]  next_pc,
  output logic             cpu_en,
  output logic             halted,
  output logic [2:0]       halt_reason,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [1:0]       dbg_state
);

  run_state_t state;

  logic             cmd_fire;
  logic             run_accept;
  logic             clr_accept;
  logic             stop_fire;
  logic             bad_cmd;
  logic             bp_hit;
  logic             self_loop;
  logic             budget_hit;
  logic             run_halt;
  logic             instr_at_limit_unused;
  logic [CNT_W-1:0] budget_cnt_unused;

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Command decode. cmd_ready is already low in ST_STEP, so cmd_fire alone
  // keeps commands out of the single-step cycle.
  // ---------------------------------------------------------------------------
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign run_accept = cmd_fire && (state == ST_HALT) && (cmd == CMD_RUN);
  assign clr_accept = cmd_fire && (cmd == CMD_CLR);
  assign stop_fire  = cmd_fire && (state == ST_RUN) && (cmd == CMD_STOP);
  assign bad_cmd    = cmd_fire && (state == ST_RUN) &&
                      ((cmd == CMD_STEP) || (cmd == CMD_RUN));

  // ---------------------------------------------------------------------------
  // Halt conditions. The breakpoint looks at next_pc so the instruction
  // leading to bp_addr still commits and the CPU parks with
  // current_pc == bp_addr, unexecuted. A RUN launched from bp_addr therefore
  // executes that instruction instead of halting on it immediately.
  // ---------------------------------------------------------------------------
  assign bp_hit    = bp_en && (next_pc == bp_addr);
  assign self_loop = (next_pc == current_pc);
  assign run_halt  = bp_hit || self_loop || budget_hit || stop_fire;

  // ---------------------------------------------------------------------------
  // Sequencer. All outputs are registered so cpu_en, halted and
  // halt_reason change together on the edge that enters or leaves HALT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_HALT;
      cpu_en      <= 1'b0;
      halted      <= 1'b1;
      halt_reason <= HR_STOP;
      cmd_ready   <= 1'b1;
      cmd_err     <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        ST_HALT: begin
          if (cmd_fire && (cmd == CMD_STEP)) begin
            state     <= ST_STEP;
            cpu_en    <= 1'b1;
            halted    <= 1'b0;
            cmd_ready <= 1'b0;
          end else if (run_accept) begin
            state     <= ST_RUN;
            cpu_en    <= 1'b1;
            halted    <= 1'b0;
            cmd_ready <= 1'b1;
          end
          // STOP in HALT is a harmless no-op; CLR_CNT is handled by the
          // instruction counter.
        end

        ST_STEP: begin
          // Exactly one committed instruction, then back to HALT.
          state       <= ST_HALT;
          cpu_en      <= 1'b0;
          halted      <= 1'b1;
          cmd_ready   <= 1'b1;
          halt_reason <= bp_hit ? HR_BREAKPOINT : HR_STEP;
        end

        ST_RUN: begin
          if (bad_cmd) begin
            cmd_err <= 1'b1;
          end
          if (run_halt) begin
            state       <= ST_HALT;
            cpu_en      <= 1'b0;
            halted      <= 1'b1;
            cmd_ready   <= 1'b1;
            halt_reason <= run_halt_reason(bp_hit, self_loop, budget_hit);
          end
        end

        default: begin
          state     <= ST_HALT;
          cpu_en    <= 1'b0;
          halted    <= 1'b1;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter visible to the PDU. Its limit compare is not
  // used; the limit register stays at zero.
  // ---------------------------------------------------------------------------
  instr_counter #(
    .CNT_W (CNT_W)
  ) u_instr_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_accept),
    .inc      (cpu_en),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .count    (instr_cnt),
    .at_limit (instr_at_limit_unused)
  );

  // ---------------------------------------------------------------------------
  // Per-RUN budget counter: zeroed and armed with run_limit when RUN is taken,
  // counts only RUN commits. Independent of instr_cnt so CLR_CNT mid-run does
  // not stretch the budget.
  // ---------------------------------------------------------------------------
  instr_counter #(
    .CNT_W (CNT_W)
  ) u_budget_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (run_accept),
    .inc      (cpu_en && (state == ST_RUN)),
    .load     (run_accept),
    .load_val (run_limit),
    .count    (budget_cnt_unused),
    .at_limit (budget_hit)
  );

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Execution sequencer for the single-cycle RV32 CPU.
- Owns `cpu_en`, the global commit enable. The PC register, RF write enable and `mem_we` are all qualified by `cpu_en` at integration.
- Accepts STOP/STEP/RUN commands from the PDU.
- Halts the CPU on breakpoint, self-loop (`next_pc == current_pc`) or an instruction budget.
- Reports halt status and a retired-instruction count back to the PDU.

Parameters:
- `PC_W`, 32, width of the PC/address compare.
- `CNT_W`, 32, width of the retired-instruction counter and run limit.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  PDU command strobe.
- `cmd`  in  2  command code: 00 STOP, 01 STEP, 10 RUN, 11 CLR_CNT.
- `cmd_ready`  out  1  command accepted this cycle when high together with `cmd_valid`.
- `cmd_err`  out  1  one-cycle pulse: a valid command was not applicable in the current state.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  PC_W  breakpoint PC.
- `run_limit`  in  CNT_W  maximum instructions per RUN; 0 = unlimited; sampled when RUN is accepted.
- `current_pc`  in  PC_W  CPU PC.
- `next_pc`  in  PC_W  CPU next PC.
- `cpu_en`  out  1  registered commit enable to the CPU.
- `halted`  out  1  high in HALT.
- `halt_reason`  out  3  000 STOP/reset, 001 STEP_DONE, 010 BREAKPOINT, 011 SELF_LOOP, 100 LIMIT.
- `instr_cnt`  out  CNT_W  retired instructions (cycles with `cpu_en`=1).

Behaviour:

Reset (`rst`=0, asynchronous):
- state HALT, `cpu_en`=0, `halted`=1, `halt_reason`=000.
- `instr_cnt`=0, internal budget counter=0.
- `cmd_err`=0, `cmd_ready`=1.

State machine (HALT, STEP, RUN); `cpu_en`=1 exactly when state is STEP or RUN.

HALT:
- `cmd_ready`=1.
- STEP → STEP.
- RUN → RUN; load budget=`run_limit`.
- CLR_CNT → `instr_cnt`=0 next cycle.
- STOP → no state change, `cmd_err`=0.

STEP:
- Lasts exactly one cycle, then → HALT with reason 001.
- If `bp_en` and `next_pc==bp_addr`, reason is 010 instead.
- `cmd_ready`=0.

RUN:
- `cmd_ready`=1.
- STOP → HALT, reason 000.
- STEP or RUN → ignored, `cmd_err` pulse.
- CLR_CNT → clears `instr_cnt`. Clear wins over that cycle's increment, so the count is 0 the next cycle.

RUN halt conditions (evaluated every cycle, transition at the edge):
- BREAKPOINT: `bp_en` && `next_pc==bp_addr`. The CPU commits the current instruction at the same edge. The CPU stops with `current_pc==bp_addr` and that instruction not executed.
- SELF_LOOP: `next_pc==current_pc`. The loop instruction has retired once.
- LIMIT: budget≠0 and retired-in-this-run == budget−1 at this cycle. Exactly `run_limit` instructions retire.
- STOP command.

Halt-reason priority when several conditions fire in one cycle: BREAKPOINT > SELF_LOOP > LIMIT > STOP.

Run start and counting:
- RUN started with `current_pc==bp_addr` executes that instruction; the compare uses `next_pc` only.
- `instr_cnt` increments in every cycle `cpu_en`=1 and wraps modulo 2^CNT_W.
- The budget counter is a separate internal counter, reset on RUN accept.

Output timing:
- `halted` and `halt_reason` are registered and update on the edge entering HALT.
- `halt_reason` holds until the next halt or reset.
- `cmd_err` is registered, one cycle after the offending command.

Reset mid-RUN aborts immediately: `cpu_en` drops asynchronously.

Decomposition:
- Package `cpu_dbg_pkg`:
  - state encoding: HALT=2'b00, STEP=2'b01, RUN=2'b10;
  - command codes CMD_STOP/CMD_STEP/CMD_RUN/CMD_CLR;
  - halt-reason codes HR_STOP…HR_LIMIT;
  - CNT_W default.
- Sub-module `instr_counter`: CNT_W counter with clear, increment and an `at_limit` compare against a loaded budget. Instantiated twice: once for `instr_cnt`, once for the run budget.

Test Plan:
1. Reset → `cpu_en`=0, `halted`=1, `halt_reason`=000, `instr_cnt`=0. STEP with pc 0x0→0x4 → `cpu_en` high exactly 1 cycle, `instr_cnt`=1, `halt_reason`=001.
2. `bp_en`=1, `bp_addr`=0x10, RUN from pc 0x0 with sequential PCs → 4 cycles of `cpu_en`, halt with `current_pc`=0x10, reason 010, `instr_cnt`=4. A second RUN executes 0x10 and continues.
3. RUN with `run_limit`=5, no breakpoint → exactly 5 `cpu_en` cycles, reason 100. Repeat with `run_limit`=0 and a self-loop at 0x20 (`next_pc`=0x20) → halt after retiring 0x20 once, reason 011.
4. RUN, STOP after 3 cycles → `cpu_en` falls at the next edge, reason 000. STEP/RUN issued during RUN → `cmd_err` pulse, no state change.
5. Same cycle: `next_pc==bp_addr` and STOP command → reason 010. CLR_CNT during RUN → `instr_cnt` reads 0 the next cycle, then 1.
6. Assert `rst`=0 asynchronously mid-RUN (between edges) → `cpu_en`=0 immediately, all outputs at reset values. After release, the next RUN restarts the count from 0.
